// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;

   localparam int REQ_CPU = 0;
   localparam int REQ_DBG = 1;

endpackage

// File: rtl/dmem_xlate.sv
// Bus byte address to memory word index translation with range/alignment check.
module dmem_xlate
   import dmem_arb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int          MEM_AW    = 11
) (
   input  logic [31:0]       addr,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              err
);

   // Word-granular offset; an address below BASE_ADDR wraps to a huge value.
   logic [29:0] word_off;

   assign word_off = addr[31:2] - BASE_ADDR[31:2];
   assign mem_addr = word_off[MEM_AW-1:0];
   assign err      = (|word_off[29:MEM_AW]) | (|addr[1:0]);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded hold sharing one data memory between CPU and debug master.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int          MEM_AW    = 11,
   parameter int          MAX_HOLD  = 8
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [31:0]       r0_addr,
   input  logic [31:0]       r0_wdata,
   output logic              r0_gnt,
   output logic [31:0]       r0_rdata,
   output logic              r0_err,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [31:0]       r1_addr,
   input  logic [31:0]       r1_wdata,
   output logic              r1_gnt,
   output logic [31:0]       r1_rdata,
   output logic              r1_err,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata
);

   localparam int              HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

   arb_state_t        state, state_nxt;
   logic              last;
   logic [HW-1:0]     hold_cnt;
   logic [MEM_AW-1:0] xa0, xa1;
   logic              xe0, xe1;

   dmem_xlate #(.BASE_ADDR(BASE_ADDR), .MEM_AW(MEM_AW)) u_xlate0 (
      .addr     (r0_addr),
      .mem_addr (xa0),
      .err      (xe0)
   );

   dmem_xlate #(.BASE_ADDR(BASE_ADDR), .MEM_AW(MEM_AW)) u_xlate1 (
      .addr     (r1_addr),
      .mem_addr (xa1),
      .err      (xe1)
   );

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         last     <= 1'(REQ_DBG);
         hold_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt == OWN0 && state != OWN0)
            last <= 1'(REQ_CPU);
         else if (state_nxt == OWN1 && state != OWN1)
            last <= 1'(REQ_DBG);
         // Staying in OWNx implies the owner was granted this cycle.
         if (state_nxt != state || state == IDLE)
            hold_cnt <= '0;
         else if (state == OWN0)
            hold_cnt <= r1_req ? hold_cnt + 1'b1 : '0;
         else
            hold_cnt <= r0_req ? hold_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (r0_req && r1_req)
               state_nxt = (last == 1'(REQ_DBG)) ? OWN0 : OWN1;
            else if (r0_req)
               state_nxt = OWN0;
            else if (r1_req)
               state_nxt = OWN1;
         end
         OWN0: begin
            if (!r0_req)
               state_nxt = r1_req ? OWN1 : IDLE;
            else if (r1_req && hold_cnt == HOLD_LAST)
               state_nxt = OWN1;
         end
         OWN1: begin
            if (!r1_req)
               state_nxt = r0_req ? OWN0 : IDLE;
            else if (r0_req && hold_cnt == HOLD_LAST)
               state_nxt = OWN0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reset gates mem_we so a write caught mid-cycle never commits.
   always_comb begin
      r0_gnt    = 1'b0;
      r0_err    = 1'b0;
      r0_rdata  = '0;
      r1_gnt    = 1'b0;
      r1_err    = 1'b0;
      r1_rdata  = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      case (state)
         OWN0: begin
            if (r0_req) begin
               r0_gnt    = 1'b1;
               r0_err    = xe0;
               r0_rdata  = xe0 ? '0 : mem_rdata;
               mem_addr  = xa0;
               mem_wdata = r0_wdata;
               mem_we    = r0_we & ~xe0 & ~reset;
            end
         end
         OWN1: begin
            if (r1_req) begin
               r1_gnt    = 1'b1;
               r1_err    = xe1;
               r1_rdata  = xe1 ? '0 : mem_rdata;
               mem_addr  = xa1;
               mem_wdata = r1_wdata;
               mem_we    = r1_we & ~xe1 & ~reset;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;

   logic        clk_in;
   logic        reset;
   logic        r0_req, r0_we, r0_gnt, r0_err;
   logic [31:0] r0_addr, r0_wdata, r0_rdata;
   logic        r1_req, r1_we, r1_gnt, r1_err;
   logic [31:0] r1_addr, r1_wdata, r1_rdata;
   logic [10:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_we;

   logic [31:0] mem [0:2047];

   int total = 0;
   int bad   = 0;
   int gcnt;

   dmem_arbiter dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .r0_req    (r0_req),
      .r0_we     (r0_we),
      .r0_addr   (r0_addr),
      .r0_wdata  (r0_wdata),
      .r0_gnt    (r0_gnt),
      .r0_rdata  (r0_rdata),
      .r0_err    (r0_err),
      .r1_req    (r1_req),
      .r1_we     (r1_we),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_gnt    (r1_gnt),
      .r1_rdata  (r1_rdata),
      .r1_err    (r1_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) if (mem_we) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
      r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
      cyc(); cyc();

      chk("rst_r0_gnt", 32'(r0_gnt), 0);
      chk("rst_r1_gnt", 32'(r1_gnt), 0);
      chk("rst_errs", 32'({r0_err, r1_err}), 0);
      chk("rst_r0_rdata", r0_rdata, 0);
      chk("rst_r1_rdata", r1_rdata, 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_state", 32'(dut.state), 0);
      chk("rst_last", 32'(dut.last), 1);
      chk("rst_hold", 32'(dut.hold_cnt), 0);
      reset = 1'b0;

      // r0 write DEADBEEF to word 1, then read it back
      r0_req = 1; r0_we = 1; r0_addr = 32'h1001_0004; r0_wdata = 32'hDEAD_BEEF;
      #1;
      chk("wr_idle_nogrant", 32'(r0_gnt), 0);
      cyc();
      chk("wr_gnt", 32'(r0_gnt), 1);
      chk("wr_mem_addr", 32'(mem_addr), 1);
      chk("wr_mem_we", 32'(mem_we), 1);
      chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("wr_err", 32'(r0_err), 0);
      cyc();
      r0_we = 0;
      #1;
      chk("rd_gnt", 32'(r0_gnt), 1);
      chk("rd_rdata", r0_rdata, 32'hDEAD_BEEF);
      chk("rd_mem_we", 32'(mem_we), 0);
      r0_req = 0;
      #1;
      chk("rel_gnt", 32'(r0_gnt), 0);
      chk("rel_rdata", r0_rdata, 0);
      cyc();
      chk("rel_idle", 32'(dut.state), 0);

      // Tie after reset: r0 first, then r1 with no bubble
      reset = 1; #1; reset = 0;
      r0_req = 1; r0_we = 0; r0_addr = 32'h1001_0004;
      r1_req = 1; r1_we = 0; r1_addr = 32'h1001_0004;
      #1;
      chk("tie_idle", 32'({r0_gnt, r1_gnt}), 0);
      cyc();
      chk("tie_r0_first", 32'({r0_gnt, r1_gnt}), 32'b10);
      chk("tie_r0_rdata", r0_rdata, 32'hDEAD_BEEF);
      r0_req = 0;
      #1;
      chk("tie_drop", 32'({r0_gnt, r1_gnt}), 0);
      cyc();
      chk("tie_r1_next", 32'({r0_gnt, r1_gnt}), 32'b01);
      chk("tie_r1_rdata", r1_rdata, 32'hDEAD_BEEF);
      chk("tie_last", 32'(dut.last), 1);
      r1_req = 0;
      cyc();
      chk("tie_back_idle", 32'(dut.state), 0);
      r0_req = 1; r1_req = 1;
      cyc();
      chk("tie2_r0_first", 32'({r0_gnt, r1_gnt}), 32'b10);

      // Bounded hold: r0 keeps requesting while r1 waits
      gcnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (r1_gnt) break;
         if (r0_gnt) gcnt++;
         cyc();
      end
      chk("hold_r0_grants", 32'(gcnt), 8);
      chk("hold_r1_gnt", 32'({r0_gnt, r1_gnt}), 32'b01);
      chk("hold_cnt_clear", 32'(dut.hold_cnt), 0);
      r0_req = 0; r1_req = 0;
      cyc();

      // Error accesses by r1
      r1_req = 1; r1_we = 1; r1_addr = 32'h1000_FFFC; r1_wdata = 32'h1234_5678;
      cyc();
      chk("oor_gnt", 32'(r1_gnt), 1);
      chk("oor_err", 32'(r1_err), 1);
      chk("oor_mem_we", 32'(mem_we), 0);
      r1_addr = 32'h1001_0002;
      #1;
      chk("mis_gnt", 32'(r1_gnt), 1);
      chk("mis_err", 32'(r1_err), 1);
      chk("mis_mem_we", 32'(mem_we), 0);
      chk("mis_rdata", r1_rdata, 0);
      r1_addr = 32'h1001_0008; r1_wdata = 32'h2222_2222;
      #1;
      chk("ok_err", 32'(r1_err), 0);
      chk("ok_mem_we", 32'(mem_we), 1);
      chk("ok_mem_addr", 32'(mem_addr), 2);
      cyc();
      r1_req = 0; r1_we = 0;
      chk("err_word1_kept", mem[1], 32'hDEAD_BEEF);
      chk("ok_word2", mem[2], 32'h2222_2222);
      cyc();

      // Reset during r0's granted write to word 2
      r0_req = 1; r0_we = 1; r0_addr = 32'h1001_0008; r0_wdata = 32'hAAAA_5555;
      cyc();
      chk("rw_mem_we", 32'(mem_we), 1);
      #1;
      reset = 1;
      #1;
      chk("rw_mem_we_drop", 32'(mem_we), 0);
      chk("rw_gnt", 32'(r0_gnt), 0);
      chk("rw_mem_addr", 32'(mem_addr), 0);
      chk("rw_mem_wdata", mem_wdata, 0);
      chk("rw_state", 32'(dut.state), 0);
      cyc();
      reset = 0; r0_req = 0; r0_we = 0;
      chk("rw_word2_kept", mem[2], 32'h2222_2222);
      chk("rw_last", 32'(dut.last), 1);

      // r1 withdraws its request before being granted
      r0_req = 1; r0_addr = 32'h1001_0004;
      cyc();
      chk("wd_r0_gnt", 32'(r0_gnt), 1);
      r1_req = 1; r1_addr = 32'h1001_0004;
      #1;
      chk("wd_r1_wait", 32'(r1_gnt), 0);
      cyc();
      chk("wd_r1_wait2", 32'(r1_gnt), 0);
      r1_req = 0;
      cyc();
      chk("wd_r1_none", 32'(r1_gnt), 0);
      r0_req = 0;
      cyc();
      chk("wd_idle", 32'(dut.state), 0);
      chk("wd_r1_final", 32'(r1_gnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the CPU core (requester 0) and a loader/debug master (requester 1). It sits between the masters and the data memory. It translates bus byte addresses into memory word indices, range-checks them, and sequences ownership with a round-robin FSM that has a bounded hold. The memory keeps its existing contract: writes are synchronous, and reads are combinational.

## Interface
Parameters:
- BASE_ADDR, 32'h10010000, bus address of memory word 0
- MEM_AW, 11, memory word-index width; the window is 4·2^MEM_AW bytes
- MAX_HOLD, 8, maximum consecutive granted accesses while the other requester waits

Ports:
- clk_in  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- r0_req / r1_req  in  1  access request; held until granted
- r0_we / r1_we  in  1  1 = write, 0 = read
- r0_addr / r1_addr  in  32  byte address
- r0_wdata / r1_wdata  in  32  write data
- r0_gnt / r1_gnt  out  1  access performed this cycle
- r0_rdata / r1_rdata  out  32  read data, valid while gnt=1, otherwise 0
- r0_err / r1_err  out  1  granted access was out of range or misaligned
- mem_addr  out  MEM_AW  memory word index
- mem_wdata  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  32  memory combinational read data

## Operation
- FSM states: IDLE, OWN0, OWN1. Pointer `last` records the most recent owner.
- IDLE:
  - Any request causes a transition to OWNx on the next edge.
  - If both requesters ask, the one with x ≠ last wins.
  - No grant is issued while in IDLE.
- OWNx routing: the owner's signals go to the memory combinationally. gnt_x = req_x. Each granted cycle is one complete access.
- OWNx transitions:
  - req_x low and other requester waiting: go to OWN(other).
  - req_x low and nobody waiting: go to IDLE.
  - req_x high and other requester waiting with hold_cnt = MAX_HOLD−1: force a switch to OWN(other).
  - Otherwise stay in OWNx.
- hold_cnt behaviour:
  - Increments on each granted cycle while the other requester is waiting.
  - Clears on any state change.
  - Clears whenever the other requester's req is low.
- `last` updates to x on entry to OWNx.
- Address translation: offset = addr − BASE_ADDR (32-bit unsigned wrap). mem_addr = offset[MEM_AW+1:2].
- Error condition: offset ≥ 4·2^MEM_AW, or addr[1:0] ≠ 0. On error:
  - gnt is still issued and err = 1.
  - mem_we is forced to 0.
  - rdata is 0.
- Non-owner outputs: gnt, err and rdata are all 0.
- Memory outputs when there is no owner or no granted access: mem_we = 0, mem_addr = 0, mem_wdata = 0.

## Timing
- Reset values: state = IDLE, last = 1 (so requester 0 wins the first tie), hold_cnt = 0. All gnt, err and rdata outputs are 0. mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Latency:
  - From IDLE: request in cycle N, grant in cycle N+1.
  - Back-to-back accesses by the owner: one per cycle.
  - Handover between owners: zero bubble (last owner access in cycle N, new owner granted in N+1).
- A write commits on the rising edge that ends its gnt cycle. Read data is combinational within the gnt cycle.
- A requester must keep req, we, addr and wdata stable until it sees gnt. Deasserting req before gnt is permitted; the cycle is dropped silently.
- Simultaneous first requests from IDLE resolve through `last`. A forced switch resolves on the same edge that completes the MAX_HOLD-th access.
- Reset asserted mid-access: mem_we is gated low combinationally by reset, so the in-flight write is not committed. The FSM returns to IDLE immediately.
- Address wrap: an addr below BASE_ADDR wraps to a huge offset and is therefore flagged as an error.

## Structure
- Package dmem_arb_pkg holds:
  - the state typedef (IDLE/OWN0/OWN1);
  - the default BASE_ADDR constant;
  - the requester index constants REQ_CPU = 0 and REQ_DBG = 1.
- Sub-module dmem_xlate: a combinational translator with addr in, and mem_addr plus err out. It is instantiated once per requester.

## Test plan
- Reset, then r0 writes 32'hDEADBEEF to 32'h10010004:
  - r0_gnt is high one cycle after the request;
  - mem_addr = 1 and mem_we = 1 in that cycle;
  - a following read returns 32'hDEADBEEF.
- r0 and r1 request simultaneously from IDLE after reset:
  - r0 is granted first;
  - once r0 drops req, r1 is granted on the next cycle with no bubble;
  - repeating the tie then favours r0 again, because last = 1.
- r0 holds req continuously while r1 waits, with MAX_HOLD = 8:
  - exactly 8 r0 grants occur;
  - r1 is granted in the next cycle;
  - hold_cnt returns to 0.
- Out-of-range and misaligned accesses:
  - r1 writes to 32'h1000FFFC: r1_gnt = 1, r1_err = 1, mem_we = 0, memory unchanged.
  - r1 writes to 32'h10010002: same response as above.
- Reset is pulsed during r0's granted write to 32'h10010008:
  - mem_we drops immediately;
  - word 2 keeps its old value;
  - all outputs take their reset values.
- r1 deasserts req before being granted while r0 owns the memory: no r1_gnt occurs, and the FSM goes to IDLE after r0 releases.
